// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and read-port address codes.
package hilo_pkg;

  // Operation codes presented on i_op when i_start is raised
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  // Control FSM states; anything other than ST_IDLE means a mul/div is in flight
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Read-port address codes
  localparam logic [1:0] ADDR_HI = 2'b10;
  localparam logic [1:0] ADDR_LO = 2'b01;

  // True for the two multiply flavours
  function automatic logic isMulOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // True for the two divide flavours
  function automatic logic isDivOp(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_div_iter.sv
// Iterative restoring divider. Works on magnitudes, produces one quotient bit
// per cycle for WIDTH cycles, then holds signed results for one fix cycle.
module hilo_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_cancel,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_lastIter,
  output logic             o_fixValid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_fix;
  logic             r_negQ;
  logic             r_negR;

  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_aMag;
  logic [WIDTH-1:0] w_bMag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qBit;
  logic [WIDTH:0]   w_quoShift;
  logic [WIDTH-1:0] w_remNext;

  // Operand magnitudes for signed divides; unsigned divides pass through raw
  always_comb begin
    w_aNeg = i_signed & i_dividend[WIDTH-1];
    w_bNeg = i_signed & i_divisor[WIDTH-1];
    w_aMag = w_aNeg ? -i_dividend : i_dividend;
    w_bMag = w_bNeg ? -i_divisor : i_divisor;
  end

  // One restoring step: shift in the next dividend bit and try to subtract.
  // A borrow out of the extra top bit means the trial subtraction failed.
  always_comb begin
    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_divisor};
    w_qBit     = ~w_diff[WIDTH];
    w_remNext  = w_qBit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quoShift = {r_quo, w_qBit};
  end

  // Iteration control and datapath registers; cancel and reset drop any work
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_fix     <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
    end else if (i_cancel) begin
      r_count <= '0;
      r_busy  <= 1'b0;
      r_fix   <= 1'b0;
    end else if (i_start) begin
      r_quo     <= w_aMag;
      r_rem     <= '0;
      r_divisor <= w_bMag;
      r_count   <= '0;
      r_busy    <= 1'b1;
      r_fix     <= 1'b0;
      r_negQ    <= w_aNeg ^ w_bNeg;
      r_negR    <= w_aNeg;
    end else if (r_busy) begin
      r_quo <= w_quoShift[WIDTH-1:0];
      r_rem <= w_remNext;
      if (r_count == LAST_STEP) begin
        r_busy  <= 1'b0;
        r_fix   <= 1'b1;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else begin
      r_fix <= 1'b0;
    end
  end

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    o_quotient  = r_negQ ? -r_quo : r_quo;
    o_remainder = r_negR ? -r_rem : r_rem;
    o_lastIter  = r_busy && (r_count == LAST_STEP);
    o_fixValid  = r_fix;
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a multi-cycle multiply/divide engine, single-cycle
// MTHI/MTLO writes and a read port that bypasses same-cycle writes.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  input  logic [1:0]       i_r_addr,
  output logic [WIDTH-1:0] o_r_data
);

  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MCW-1:0] MUL_LOAD = MCW'(MUL_CYCLES - 1);

  state_e             r_state;
  logic [MCW-1:0]     r_mulCount;
  logic [2*WIDTH-1:0] r_product;
  logic               r_divZero;
  logic               r_mulPend;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_idle;
  logic               w_accept;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_mulStart;
  logic               w_divStart;
  logic               w_signedMul;
  logic [2*WIDTH-1:0] w_aExt;
  logic [2*WIDTH-1:0] w_bExt;
  logic [2*WIDTH-1:0] w_product;
  logic               w_mulDoneRaw;
  logic               w_divDoneRaw;
  logic               w_mulWrite;
  logic               w_divWrite;
  logic [WIDTH-1:0]   w_hiNext;
  logic [WIDTH-1:0]   w_loNext;
  logic [WIDTH-1:0]   w_divQuo;
  logic [WIDTH-1:0]   w_divRem;
  logic               w_divLast;
  logic               w_divFixValid;

  // Issue decode: start only counts in IDLE and never alongside cancel
  always_comb begin
    w_idle      = (r_state == ST_IDLE);
    w_accept    = i_start & ~i_cancel & w_idle;
    w_mthi      = w_accept && (i_op == OP_MTHI);
    w_mtlo      = w_accept && (i_op == OP_MTLO);
    w_mulStart  = w_accept && isMulOp(i_op);
    w_divStart  = w_accept && isDivOp(i_op);
    w_signedMul = (i_op == OP_MULT);
  end

  // Full-width product; sign-extending both operands to 2*WIDTH lets one
  // unsigned multiplier serve MULT and MULTU alike
  always_comb begin
    w_aExt    = {{WIDTH{w_signedMul & i_src_a[WIDTH-1]}}, i_src_a};
    w_bExt    = {{WIDTH{w_signedMul & i_src_b[WIDTH-1]}}, i_src_b};
    w_product = w_aExt * w_bExt;
  end

  hilo_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (w_divStart),
    .i_signed   (i_op == OP_DIV),
    .i_dividend (i_src_a),
    .i_divisor  (i_src_b),
    .i_cancel   (i_cancel),
    .o_quotient (w_divQuo),
    .o_remainder(w_divRem),
    .o_lastIter (w_divLast),
    .o_fixValid (w_divFixValid)
  );

  // Completion and write qualification; cancel in the done cycle kills both
  always_comb begin
    w_mulDoneRaw  = ((r_state == ST_MUL) && (r_mulCount == '0)) || r_mulPend;
    w_divDoneRaw  = (r_state == ST_FIX) & w_divFixValid;
    w_mulWrite    = w_mulDoneRaw & ~i_cancel;
    w_divWrite    = w_divDoneRaw & ~i_cancel & ~r_divZero;
    o_busy        = ~w_idle;
    o_done        = (w_mulDoneRaw | w_divDoneRaw) & ~i_cancel;
    o_div_by_zero = w_divDoneRaw & ~i_cancel & r_divZero;
  end

  // Control FSM: latency counter for multiplies, sequencing for divides
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_mulCount <= '0;
      r_product  <= '0;
      r_divZero  <= 1'b0;
      r_mulPend  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mulPend <= 1'b0;
          if (w_mulStart) begin
            r_product <= w_product;
            if (MUL_CYCLES == 1) begin
              r_mulPend <= 1'b1;
            end else begin
              r_state    <= ST_MUL;
              r_mulCount <= MUL_LOAD;
            end
          end else if (w_divStart) begin
            r_state   <= ST_DIV;
            r_divZero <= (i_src_b == '0);
          end
        end
        ST_MUL: begin
          if (i_cancel || (r_mulCount == '0)) begin
            r_state    <= ST_IDLE;
            r_mulCount <= '0;
          end else begin
            r_mulCount <= r_mulCount - 1'b1;
          end
        end
        ST_DIV: begin
          if (i_cancel) begin
            r_state <= ST_IDLE;
          end else if (w_divLast) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Next HI/LO values; an MT op issued in a MUL_CYCLES=1 done cycle is the
  // younger instruction, so it wins over the pending product
  always_comb begin
    w_hiNext = r_hi;
    w_loNext = r_lo;
    if (w_mthi) begin
      w_hiNext = i_src_a;
    end else if (w_mulWrite) begin
      w_hiNext = r_product[2*WIDTH-1:WIDTH];
    end else if (w_divWrite) begin
      w_hiNext = w_divRem;
    end
    if (w_mtlo) begin
      w_loNext = i_src_a;
    end else if (w_mulWrite) begin
      w_loNext = r_product[WIDTH-1:0];
    end else if (w_divWrite) begin
      w_loNext = w_divQuo;
    end
  end

  // HI/LO storage
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_hi <= w_hiNext;
      r_lo <= w_loNext;
    end
  end

  // Read port returns the post-edge value so a same-cycle write is visible
  always_comb begin
    case (i_r_addr)
      ADDR_HI: o_r_data = w_hiNext;
      ADDR_LO: o_r_data = w_loNext;
      default: o_r_data = '0;
    endcase
  end

endmodule
